// File: rtl/perceptron_accum_if.sv
// perceptron_accum_if: term-in / result-out handshake bundle for perceptron_accum
//   master: upstream/downstream driver (val_i, data_i, bias_i, rdy_i out; rdy_o, val_o, sum_o, act_o, sat_o in)
//   slave : the accumulator itself (mirror directions)
interface perceptron_accum_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24
);
    logic                     val_i;
    logic                     rdy_o;
    logic signed [DATA_W-1:0] data_i;
    logic signed [ACC_W-1:0]  bias_i;
    logic                     val_o;
    logic                     rdy_i;
    logic signed [ACC_W-1:0]  sum_o;
    logic                     act_o;
    logic                     sat_o;
    modport master (
        output val_i, data_i, bias_i, rdy_i,
        input  rdy_o, val_o, sum_o, act_o, sat_o
    );
    modport slave (
        input  val_i, data_i, bias_i, rdy_i,
        output rdy_o, val_o, sum_o, act_o, sat_o
    );
endinterface

// File: rtl/perceptron_accum.sv
// perceptron_accum: saturating bias + N_IN-term accumulator with step activation
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : val_i/rdy_o/data_i/bias_i term input, val_o/rdy_i/sum_o/act_o/sat_o result output
module perceptron_accum #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24,
    parameter int N_IN   = 4
) (
    input logic clk,
    input logic reset,
    perceptron_accum_if.slave bus
);
    localparam int CW = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};
    logic [CW-1:0]           cnt;
    logic signed [ACC_W-1:0] acc, base, sat_sum;
    logic signed [ACC_W:0]   raw;
    logic                    sat_f, first, last, accept, ovf, flag;
    assign bus.rdy_o = !bus.val_o || bus.rdy_i;
    always_comb begin
        accept  = bus.val_i && bus.rdy_o;
        first   = cnt == '0;
        last    = cnt == CW'(N_IN - 1);
        base    = first ? bus.bias_i : acc;
        // one guard bit: overflow shows up as disagreement of the top two bits
        raw     = {base[ACC_W-1], base} + {{(ACC_W + 1 - DATA_W){bus.data_i[DATA_W-1]}}, bus.data_i};
        ovf     = raw[ACC_W] != raw[ACC_W-1];
        sat_sum = ovf ? (raw[ACC_W] ? MIN_V : MAX_V) : raw[ACC_W-1:0];
        flag    = ovf || (!first && sat_f);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            sat_f     <= 1'b0;
            bus.val_o <= 1'b0;
            bus.sum_o <= '0;
            bus.act_o <= 1'b0;
            bus.sat_o <= 1'b0;
        end else begin
            if (accept) begin
                acc   <= sat_sum;
                sat_f <= flag;
                cnt   <= last ? '0 : cnt + CW'(1);
            end
            // a new result may replace the one draining this cycle
            if (accept && last) begin
                bus.val_o <= 1'b1;
                bus.sum_o <= sat_sum;
                bus.act_o <= !sat_sum[ACC_W-1] && |sat_sum;
                bus.sat_o <= flag;
            end else if (bus.rdy_i) begin
                bus.val_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_perceptron_accum.sv
// tb_perceptron_accum: randomized + directed check of perceptron_accum against a queue-based model
module tb_perceptron_accum;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 24;
    localparam int N_IN   = 4;
    localparam longint MAXV = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (ACC_W - 1));

    typedef struct {
        longint sum;
        bit     sat;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    perceptron_accum_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
    perceptron_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_IN(N_IN)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    res_t q[$];
    int m_cnt = 0;
    longint m_acc = 0;
    bit m_sat = 0;
    longint m_raw;
    bit m_ovf, m_rdy;
    int rdy_mode = 0;
    int lit_tag = 0;
    int lit_seen = 0;
    bit lit_val, lit_act, lit_sat;
    longint lit_sum;
    bit exp_v;

    // downstream ready: 0 = always ready, 1 = random, 2 = stalled
    always @(posedge clk) begin
        #1;
        bus.rdy_i = rdy_mode == 1 ? 1'($urandom_range(0, 1)) : rdy_mode != 2;
    end

    // reference model: whole-number sums clamped to the accumulator range
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_cnt = 0;
            m_acc = 0;
            m_sat = 0;
        end else begin
            m_rdy = q.size() == 0 || bus.rdy_i;
            if (q.size() != 0 && bus.rdy_i) void'(q.pop_front());
            if (bus.val_i && m_rdy) begin
                m_raw = (m_cnt == 0 ? longint'($signed(bus.bias_i)) : m_acc) + longint'($signed(bus.data_i));
                m_ovf = m_raw > MAXV || m_raw < MINV;
                m_acc = m_raw > MAXV ? MAXV : m_raw < MINV ? MINV : m_raw;
                m_sat = (m_cnt != 0 && m_sat) || m_ovf;
                m_cnt++;
                if (m_cnt == N_IN) begin
                    m_cnt = 0;
                    q.push_back('{m_acc, m_sat});
                end
            end
        end
    end

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_v = q.size() != 0;
        chk("val_o", bus.val_o, exp_v);
        chk("rdy_o", bus.rdy_o, !exp_v || bus.rdy_i);
        if (exp_v) begin
            chk("sum_o", $signed(bus.sum_o), q[0].sum);
            chk("act_o", bus.act_o, q[0].sum > 0);
            chk("sat_o", bus.sat_o, q[0].sat);
        end
        if (lit_tag != lit_seen) begin
            lit_seen = lit_tag;
            chk("lit_val", bus.val_o, lit_val);
            chk("lit_sum", $signed(bus.sum_o), lit_sum);
            chk("lit_act", bus.act_o, lit_act);
            chk("lit_sat", bus.sat_o, lit_sat);
            chk("model_val", exp_v, lit_val);
            if (exp_v) chk("model_sum", q[0].sum, lit_sum);
        end
    end

    task automatic lit(input bit v, input longint s, input bit a, input bit sa);
        lit_val = v;
        lit_sum = s;
        lit_act = a;
        lit_sat = sa;
        lit_tag++;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic signed [ACC_W-1:0] b, input logic signed [DATA_W-1:0] d);
        bit ok;
        int tries = 0;
        bus.val_i = 1'b1;
        bus.bias_i = b;
        bus.data_i = d;
        do begin
            #1;
            ok = bus.rdy_o;
            @(posedge clk);
            #2;
            tries++;
            if (tries > 1000) begin
                $display("FAIL send_timeout: got no acceptance expected one within 1000 cycles");
                $fatal(1);
            end
        end while (!ok);
    endtask

    initial begin
        bus.val_i = 1'b0;
        bus.data_i = '0;
        bus.bias_i = '0;
        cyc(3);
        reset = 1'b0;
        lit(0, 0, 0, 0);
        cyc(2);
        // bias 10 + 1+2+3+4
        for (int i = 1; i <= 4; i++) send(10, 16'(i));
        bus.val_i = 1'b0;
        lit(1, 20, 1, 0);
        cyc(3);
        // held result under backpressure
        rdy_mode = 2;
        send(0, -5);
        send(0, 2);
        send(0, 1);
        send(0, 1);
        bus.val_i = 1'b0;
        lit(1, -1, 0, 0);
        cyc(5);
        lit(1, -1, 0, 0);
        rdy_mode = 0;
        cyc(3);
        // positive clamp then decrement
        send(24'sd8388607, 100);
        send(0, -1);
        send(0, 0);
        send(0, 0);
        bus.val_i = 1'b0;
        lit(1, 8388606, 1, 1);
        cyc(3);
        // two streamed vectors, no stall
        for (int i = 0; i < 8; i++) send(24'(5 + i), 16'(i * 3 - 7));
        bus.val_i = 1'b0;
        cyc(3);
        // reset mid-vector discards partial terms
        send(1000, 7);
        send(1000, 7);
        bus.val_i = 1'b0;
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 1);
        bus.val_i = 1'b0;
        lit(1, 4, 1, 0);
        cyc(3);
        // random throttling on both sides
        rdy_mode = 1;
        for (int v = 0; v < 1000; v++) begin
            for (int t = 0; t < N_IN; t++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.val_i = 1'b0;
                    cyc($urandom_range(1, 2));
                end
                send($urandom_range(0, 3) == 0 ? ACC_W'(MAXV - 24'($urandom_range(0, 50))) : ACC_W'($urandom),
                     DATA_W'($urandom));
            end
        end
        bus.val_i = 1'b0;
        rdy_mode = 0;
        cyc(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
